// File: rtl/pipe_adder_pkg.sv
// pipe_adder_pkg: bit-level adder cells and flag helpers shared by pipe_adder and its slices.
package pipe_adder_pkg;

   function automatic logic [1:0] half_add(input logic x, input logic y);
      return {x & y, x ^ y};
   endfunction

   // Full adder from two chained half adders; result is {cout, s}.
   function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
      logic [1:0] h0;
      logic [1:0] h1;
      h0 = half_add(x, y);
      h1 = half_add(h0[0], ci);
      return {h0[1] | h1[1], h1[0]};
   endfunction

   function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
      return (a_msb == b_msb) && (s_msb != a_msb);
   endfunction

endpackage

// File: rtl/adder_slice.sv
// adder_slice: combinational CHUNK-bit add with carry-in; bit 0 uses the full-adder cell.
module adder_slice
   import pipe_adder_pkg::*;
#(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] s,
   output logic             cout
);

   logic [1:0] bit0;

   assign bit0 = full_add(a[0], b[0], cin);
   assign s[0] = bit0[0];

   generate
      if (CHUNK > 1) begin : g_upper
         assign {cout, s[CHUNK-1:1]} = {1'b0, a[CHUNK-1:1]} + {1'b0, b[CHUNK-1:1]}
                                       + CHUNK'(bit0[1]);
      end else begin : g_single
         assign cout = bit0[1];
      end
   endgenerate

endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: WIDTH-bit add/subtract split into STAGES registered carry-chain slices,
// with a single global advance so backpressure freezes the whole pipe.
module pipe_adder
   import pipe_adder_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             overflow,
   output logic             zero
);

   localparam int CHUNK = WIDTH / STAGES;
   localparam int MSB   = WIDTH - 1;

   logic             adv;
   // Per-stage inputs: full operand words travel along so later chunks stay aligned.
   logic [WIDTH-1:0] a_st     [STAGES];
   logic [WIDTH-1:0] bp_st    [STAGES];
   logic [WIDTH-1:0] ps_st    [STAGES];
   logic             cin_st   [STAGES];
   logic             valid_st [STAGES];

   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   assign a_st[0]     = a;
   assign bp_st[0]    = sub ? ~b : b;
   assign ps_st[0]    = '0;
   assign cin_st[0]   = sub;
   assign valid_st[0] = in_valid;

   generate
      for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
         logic [CHUNK-1:0] s_chunk;
         logic             c_out;
         logic [WIDTH-1:0] ps_next;

         adder_slice #(.CHUNK(CHUNK)) u_slice (
            .a    (CHUNK'(a_st[gi] >> (gi * CHUNK))),
            .b    (CHUNK'(bp_st[gi] >> (gi * CHUNK))),
            .cin  (cin_st[gi]),
            .s    (s_chunk),
            .cout (c_out)
         );

         assign ps_next = ps_st[gi] | (WIDTH'(s_chunk) << (gi * CHUNK));

         if (gi < STAGES - 1) begin : g_mid
            logic [WIDTH-1:0] a_reg;
            logic [WIDTH-1:0] bp_reg;
            logic [WIDTH-1:0] ps_reg;
            logic             carry_reg;
            logic             valid_reg;

            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  a_reg     <= '0;
                  bp_reg    <= '0;
                  ps_reg    <= '0;
                  carry_reg <= 1'b0;
                  valid_reg <= 1'b0;
               end else if (adv) begin
                  a_reg     <= a_st[gi];
                  bp_reg    <= bp_st[gi];
                  ps_reg    <= ps_next;
                  carry_reg <= c_out;
                  valid_reg <= valid_st[gi];
               end
            end

            assign a_st[gi+1]     = a_reg;
            assign bp_st[gi+1]    = bp_reg;
            assign ps_st[gi+1]    = ps_reg;
            assign cin_st[gi+1]   = carry_reg;
            assign valid_st[gi+1] = valid_reg;
         end else begin : g_last
            // Flags are formed from the completed word and registered with it.
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  out_valid <= 1'b0;
                  sum       <= '0;
                  carry     <= 1'b0;
                  overflow  <= 1'b0;
                  zero      <= 1'b0;
               end else if (adv) begin
                  out_valid <= valid_st[gi];
                  sum       <= ps_next;
                  carry     <= c_out;
                  overflow  <= signed_ovf(a_st[gi][MSB], bp_st[gi][MSB], ps_next[MSB]);
                  zero      <= ~|ps_next;
               end
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: directed table, stalled stream, mid-flight reset and random checks of pipe_adder
// across 8/2, 32/4, 16/1 and 16/16 configurations, using per-instance scoreboards.
module tb_pipe_adder;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [35:0] got, input logic [35:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Reference: {sum[31:0], carry, overflow, zero} for a w-bit add/sub.
   function automatic logic [34:0] model(input int w, input logic [31:0] x, input logic [31:0] y,
                                         input logic s);
      logic [63:0] m, xm, ym, t;
      logic [31:0] r;
      logic        c, o, z;
      m  = (64'd1 << w) - 64'd1;
      xm = {32'd0, x} & m;
      ym = (s ? ~{32'd0, y} : {32'd0, y}) & m;
      t  = xm + ym + {63'd0, s};
      r  = t[31:0] & m[31:0];
      c  = t[w];
      o  = (xm[w-1] == ym[w-1]) && (r[w-1] != xm[w-1]);
      z  = (r == 32'd0);
      return {r, c, o, z};
   endfunction

   // ---- 8-bit, 2-stage instance ----
   logic iv8, ir8, sub8, ov8, or8, c8, o8, z8;
   logic [7:0] a8, b8, sum8;
   logic [10:0] exp8;
   pipe_adder #(.WIDTH(8), .STAGES(2)) u8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .sub(sub8),
      .out_valid(ov8), .out_ready(or8), .sum(sum8), .carry(c8), .overflow(o8), .zero(z8));

   // ---- 32-bit, 4-stage instance (defaults) ----
   logic iv32, ir32, sub32, ov32, or32, c32, o32, z32;
   logic [31:0] a32, b32, sum32;
   pipe_adder u32 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32), .sub(sub32),
      .out_valid(ov32), .out_ready(or32), .sum(sum32), .carry(c32), .overflow(o32), .zero(z32));

   // ---- 16-bit instances, STAGES=1 and STAGES=WIDTH, sharing stimulus ----
   logic iv16, sub16, or16;
   logic [15:0] a16, b16;
   logic ira, ova, ca, oa, za, irb, ovb, cb, ob, zb;
   logic [15:0] suma, sumb;
   pipe_adder #(.WIDTH(16), .STAGES(1)) u16a (
      .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ira), .a(a16), .b(b16), .sub(sub16),
      .out_valid(ova), .out_ready(or16), .sum(suma), .carry(ca), .overflow(oa), .zero(za));
   pipe_adder #(.WIDTH(16), .STAGES(16)) u16b (
      .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(irb), .a(a16), .b(b16), .sub(sub16),
      .out_valid(ovb), .out_ready(or16), .sum(sumb), .carry(cb), .overflow(ob), .zero(zb));

   logic [34:0] q8[$], q32[$], q16a[$], q16b[$];
   int n_out8 = 0, n_out32 = 0, n_outa = 0, n_outb = 0, n_acca = 0, n_accb = 0, n_stall = 0;
   logic        stall_prev32 = 1'b0;
   logic [35:0] snap32;

   task automatic unexpected(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: got output with empty scoreboard, required none", name);
   endtask

   // Scoreboards: pop on output handshake, push on input handshake.
   always @(negedge clk) begin
      if (ov8 && or8) begin
         n_out8++;
         if (q8.size() == 0) unexpected("u8_result");
         else check("u8_result", {24'd0, sum8, c8, o8, z8}, q8.pop_front());
      end
      if (iv8 && ir8) q8.push_back({24'd0, exp8});
   end

   always @(negedge clk) begin
      if (stall_prev32) check("u32_hold", {ov32, sum32, c32, o32, z32}, snap32);
      if (ov32 && !or32) begin
         check("u32_in_ready_stall", {35'd0, ir32}, 36'd0);
         n_stall++;
      end
      stall_prev32 = ov32 && !or32;
      snap32 = {ov32, sum32, c32, o32, z32};
      if (ov32 && or32) begin
         n_out32++;
         if (q32.size() == 0) unexpected("u32_result");
         else check("u32_result", {sum32, c32, o32, z32}, q32.pop_front());
      end
      if (iv32 && ir32) q32.push_back(model(32, a32, b32, sub32));
   end

   always @(negedge clk) begin
      if (ova && or16) begin
         n_outa++;
         if (q16a.size() == 0) unexpected("u16s1_result");
         else check("u16s1_result", {16'd0, suma, ca, oa, za}, q16a.pop_front());
      end
      if (ovb && or16) begin
         n_outb++;
         if (q16b.size() == 0) unexpected("u16s16_result");
         else check("u16s16_result", {16'd0, sumb, cb, ob, zb}, q16b.pop_front());
      end
      if (iv16 && ira) begin
         n_acca++;
         q16a.push_back(model(16, {16'd0, a16}, {16'd0, b16}, sub16));
      end
      if (iv16 && irb) begin
         n_accb++;
         q16b.push_back(model(16, {16'd0, a16}, {16'd0, b16}, sub16));
      end
   end

   task automatic drain(input string name);
      int n = 0;
      while ((q8.size() + q32.size() + q16a.size() + q16b.size()) != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      #1;
      check(name, 36'(q8.size() + q32.size() + q16a.size() + q16b.size()), 36'd0);
   endtask

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       sub;
      logic [7:0] s;
      logic       c;
      logic       o;
      logic       z;
   } vec_t;

   vec_t tbl[9];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
      tbl[2] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
      tbl[3] = '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0};
      tbl[4] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0};
      tbl[5] = '{8'h05, 8'h05, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
      tbl[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
      tbl[7] = '{8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};
      tbl[8] = '{8'h3C, 8'hC4, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};

      rst_n = 1'b0;
      iv8 = 0; a8 = 0; b8 = 0; sub8 = 0; or8 = 1; exp8 = 0;
      iv32 = 0; a32 = 0; b32 = 0; sub32 = 0; or32 = 1;
      iv16 = 0; a16 = 0; b16 = 0; sub16 = 0; or16 = 1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_u8_outs", {24'd0, ov8, sum8, c8, o8, z8}, 36'd0);
      check("rst_u32_outs", {ov32, sum32, c32, o32, z32}, 36'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_in_ready", {32'd0, ir8, ir32, ira, irb}, 36'hF);

      // Directed table: first vector checks latency, rest stream back-to-back.
      @(posedge clk); #1;
      iv8 = 1; a8 = tbl[0].a; b8 = tbl[0].b; sub8 = tbl[0].sub;
      exp8 = {tbl[0].s, tbl[0].c, tbl[0].o, tbl[0].z};
      @(posedge clk); #1;
      iv8 = 0;
      @(negedge clk);
      check("u8_lat_edge1", {35'd0, ov8}, 36'd0);
      @(negedge clk);
      check("u8_lat_edge2", {35'd0, ov8}, 36'd1);
      @(posedge clk); #1;
      for (int i = 1; i < 9; i++) begin
         iv8 = 1; a8 = tbl[i].a; b8 = tbl[i].b; sub8 = tbl[i].sub;
         exp8 = {tbl[i].s, tbl[i].c, tbl[i].o, tbl[i].z};
         @(posedge clk); #1;
      end
      iv8 = 0;
      drain("u8_drain");
      check("u8_count", 36'(n_out8), 36'd9);

      // 16 back-to-back ops on the default pipe with out_ready low for cycles 5-8.
      begin
         logic [31:0] sa[16], sb[16];
         logic        ss[16];
         int          idx = 0;
         logic        acc;
         for (int i = 0; i < 16; i++) begin
            sa[i] = $urandom; sb[i] = $urandom; ss[i] = 1'($urandom_range(0, 1));
         end
         sa[3] = 32'hFFFF_FFFF; sb[3] = 32'd1; ss[3] = 1'b0;
         n_out32 = 0;
         @(posedge clk); #1;
         for (int cyc = 0; cyc < 200 && idx < 16; cyc++) begin
            or32 = !(cyc >= 5 && cyc <= 8);
            iv32 = 1; a32 = sa[idx]; b32 = sb[idx]; sub32 = ss[idx];
            @(negedge clk);
            acc = ir32;
            @(posedge clk); #1;
            if (acc) idx++;
         end
         iv32 = 0; or32 = 1;
         check("u32_all_issued", 36'(idx), 36'd16);
         drain("u32_drain");
         check("u32_count", 36'(n_out32), 36'd16);
         check("u32_stall_seen", 36'(n_stall >= 4), 36'd1);
      end

      // Reset with one result at the output and three ops in flight.
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
         iv32 = 1; a32 = $urandom; b32 = $urandom; sub32 = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
      end
      iv32 = 0;
      check("u32_pre_rst_valid", {35'd0, ov32}, 36'd1);
      #1 rst_n = 1'b0;
      #1;
      check("u32_rst_async_outs", {ov32, sum32, c32, o32, z32}, 36'd0);
      q8.delete(); q32.delete(); q16a.delete(); q16b.delete();
      repeat (2) @(posedge clk);
      #1;
      check("u32_rst_held", {35'd0, ov32}, 36'd0);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("u32_post_rst_ready", {34'd0, ir32, ov32}, 36'd2);
      @(posedge clk); #1;
      iv32 = 1; a32 = 32'h8000_0000; b32 = 32'h8000_0000; sub32 = 1'b0;
      @(posedge clk); #1;
      iv32 = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("u32_post_rst_lat", {35'd0, ov32}, {35'd0, k == 3});
         if (k < 3) @(posedge clk);
      end
      drain("u32_rst_drain");

      // Random vectors on STAGES=1 and STAGES=WIDTH with random bubbles and backpressure.
      @(posedge clk); #1;
      for (int i = 0; i < 1200; i++) begin
         iv16  = ($urandom_range(0, 7) != 0);
         a16   = 16'($urandom);
         b16   = 16'($urandom);
         sub16 = 1'($urandom_range(0, 1));
         or16  = ($urandom_range(0, 3) != 0);
         if (i % 97 == 0) begin
            a16 = 16'hFFFF; b16 = 16'h0001; sub16 = 1'b0;
         end
         @(posedge clk); #1;
      end
      iv16 = 0; or16 = 1;
      drain("u16_drain");
      check("u16s1_count", 36'(n_outa), 36'(n_acca));
      check("u16s16_count", 36'(n_outb), 36'(n_accb));
      check("u16_enough", 36'(n_acca >= 600 && n_accb >= 600), 36'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
